// File: rtl/if_fetch_req_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_req_ctrl
// Instruction-fetch request sequencer between the IF stage and an SRAM-like
// inst_ram port with split address/data handshakes.
//  - Issues fetch requests only while outstanding + buffered < MAX_OUT, so the
//    response FIFO can never overflow (credit scheme).
//  - Keeps the PC of every in-flight request in a PC FIFO.
//  - On flush, marks all in-flight responses stale and drops them on return.
//  - Buffers returned {pc, instruction pair} until the IF/ID register accepts.
// Ports:
//  clk, rst_n                 clock, synchronous active-low reset
//  fetch_valid_i/fetch_pc_i   fetch request from IF; fetch_ready_o = accepted
//  flush_i                    exception or branch flush
//  inst_req_o/inst_addr_o     request to inst_ram; inst_addr_ok_i accepts it
//  inst_data_ok_i/inst_rdata_i returned 64-bit instruction pair
//  resp_valid_o/resp_pc_o/resp_rdata_o/resp_ready_i  buffered pair to IF/ID
//  outstanding_o              requests issued but not yet answered
//  discard_cnt_o              pending responses that will be dropped
// ----------------------------------------------------------------------------
module if_fetch_req_ctrl #(
   parameter int MAX_OUT = 2,
   parameter int CNT_W   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_valid_i,
   input  logic [31:0]      fetch_pc_i,
   output logic             fetch_ready_o,
   input  logic             flush_i,
   output logic             inst_req_o,
   output logic [31:0]      inst_addr_o,
   input  logic             inst_addr_ok_i,
   input  logic             inst_data_ok_i,
   input  logic [63:0]      inst_rdata_i,
   output logic             resp_valid_o,
   output logic [31:0]      resp_pc_o,
   output logic [63:0]      resp_rdata_o,
   input  logic             resp_ready_i,
   output logic [CNT_W-1:0] outstanding_o,
   output logic [CNT_W-1:0] discard_cnt_o
);

   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   // Circular pointer increment that also works for non-power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUT - 1)) begin
         ptr_inc = {PTR_W{1'b0}};
      end else begin
         ptr_inc = p + PTR_W'(1'b1);
      end
   endfunction

   logic [CNT_W-1:0] out_cnt_r, disc_cnt_r, resp_cnt_r;
   logic [CNT_W-1:0] out_nxt_s, disc_nxt_s, resp_nxt_s;
   logic [31:0]      pc_fifo_r  [MAX_OUT];
   logic [PTR_W-1:0] pc_wr_ptr_r, pc_rd_ptr_r;
   logic [31:0]      rsp_pc_r   [MAX_OUT];
   logic [63:0]      rsp_data_r [MAX_OUT];
   logic [PTR_W-1:0] rsp_wr_ptr_r, rsp_rd_ptr_r;

   logic credit_ok_s, inst_req_s, accept_s, ret_s, drop_s, push_rsp_s, pop_rsp_s;

   // Handshake decode and next-state computation for all counters.
   always_comb begin
      credit_ok_s = ({1'b0, out_cnt_r} + {1'b0, resp_cnt_r}) < (CNT_W + 1)'(MAX_OUT);
      inst_req_s  = fetch_valid_i & ~flush_i & credit_ok_s;
      accept_s    = inst_req_s & inst_addr_ok_i;
      // A return with nothing outstanding is a protocol violation: ignore it.
      ret_s       = inst_data_ok_i & (out_cnt_r != {CNT_W{1'b0}});
      drop_s      = ret_s & ((disc_cnt_r != {CNT_W{1'b0}}) | flush_i);
      push_rsp_s  = ret_s & ~drop_s;
      pop_rsp_s   = (resp_cnt_r != {CNT_W{1'b0}}) & resp_ready_i & ~flush_i;

      out_nxt_s   = out_cnt_r + CNT_W'(accept_s) - CNT_W'(ret_s);

      // Flush re-marks every response still in flight after this cycle as stale.
      if (flush_i) begin
         disc_nxt_s = out_nxt_s;
      end else if (ret_s && (disc_cnt_r != {CNT_W{1'b0}})) begin
         disc_nxt_s = disc_cnt_r - CNT_W'(1'b1);
      end else begin
         disc_nxt_s = disc_cnt_r;
      end

      if (flush_i) begin
         resp_nxt_s = {CNT_W{1'b0}};
      end else if (push_rsp_s && !pop_rsp_s) begin
         resp_nxt_s = resp_cnt_r + CNT_W'(1'b1);
      end else if (pop_rsp_s && !push_rsp_s) begin
         resp_nxt_s = resp_cnt_r - CNT_W'(1'b1);
      end else begin
         resp_nxt_s = resp_cnt_r;
      end
   end

   // Counters, PC FIFO and response FIFO state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_cnt_r    <= {CNT_W{1'b0}};
         disc_cnt_r   <= {CNT_W{1'b0}};
         resp_cnt_r   <= {CNT_W{1'b0}};
         pc_wr_ptr_r  <= {PTR_W{1'b0}};
         pc_rd_ptr_r  <= {PTR_W{1'b0}};
         rsp_wr_ptr_r <= {PTR_W{1'b0}};
         rsp_rd_ptr_r <= {PTR_W{1'b0}};
         for (int i = 0; i < MAX_OUT; i++) begin
            pc_fifo_r[i]  <= 32'h0000_0000;
            rsp_pc_r[i]   <= 32'h0000_0000;
            rsp_data_r[i] <= 64'h0;
         end
      end else begin
         out_cnt_r  <= out_nxt_s;
         disc_cnt_r <= disc_nxt_s;
         resp_cnt_r <= resp_nxt_s;

         // PC FIFO is never cleared by flush so pops stay aligned with returns.
         if (accept_s) begin
            pc_fifo_r[pc_wr_ptr_r] <= fetch_pc_i;
            pc_wr_ptr_r            <= ptr_inc(pc_wr_ptr_r);
         end
         if (ret_s) begin
            pc_rd_ptr_r <= ptr_inc(pc_rd_ptr_r);
         end

         if (push_rsp_s) begin
            rsp_pc_r[rsp_wr_ptr_r]   <= pc_fifo_r[pc_rd_ptr_r];
            rsp_data_r[rsp_wr_ptr_r] <= inst_rdata_i;
         end
         if (flush_i) begin
            rsp_wr_ptr_r <= {PTR_W{1'b0}};
            rsp_rd_ptr_r <= {PTR_W{1'b0}};
         end else begin
            if (push_rsp_s) begin
               rsp_wr_ptr_r <= ptr_inc(rsp_wr_ptr_r);
            end
            if (pop_rsp_s) begin
               rsp_rd_ptr_r <= ptr_inc(rsp_rd_ptr_r);
            end
         end
      end
   end

   assign inst_req_o    = inst_req_s;
   assign inst_addr_o   = fetch_pc_i;
   assign fetch_ready_o = accept_s;
   assign resp_valid_o  = (resp_cnt_r != {CNT_W{1'b0}});
   assign resp_pc_o     = rsp_pc_r[rsp_rd_ptr_r];
   assign resp_rdata_o  = rsp_data_r[rsp_rd_ptr_r];
   assign outstanding_o = out_cnt_r;
   assign discard_cnt_o = disc_cnt_r;

endmodule

// File: tb/tb_if_fetch_req_ctrl.sv
module tb_if_fetch_req_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid_i;
   logic [31:0] fetch_pc_i;
   logic        fetch_ready_o;
   logic        flush_i;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic        inst_addr_ok_i;
   logic        inst_data_ok_i;
   logic [63:0] inst_rdata_i;
   logic        resp_valid_o;
   logic [31:0] resp_pc_o;
   logic [63:0] resp_rdata_o;
   logic        resp_ready_i;
   logic [1:0]  outstanding_o;
   logic [1:0]  discard_cnt_o;

   int errors = 0;
   int checks = 0;

   if_fetch_req_ctrl #(.MAX_OUT(2), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o),
      .flush_i(flush_i),
      .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o), .inst_addr_ok_i(inst_addr_ok_i),
      .inst_data_ok_i(inst_data_ok_i), .inst_rdata_i(inst_rdata_i),
      .resp_valid_o(resp_valid_o), .resp_pc_o(resp_pc_o), .resp_rdata_o(resp_rdata_o),
      .resp_ready_i(resp_ready_i),
      .outstanding_o(outstanding_o), .discard_cnt_o(discard_cnt_o)
   );

   // 10-time-unit clock.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counter invariant discard <= outstanding <= MAX_OUT on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check_eq("invariant", {63'd0, (discard_cnt_o <= outstanding_o) && (outstanding_o <= 2'd2)}, 64'd1);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fetch_valid_i  = 1'b0;
      fetch_pc_i     = 32'h0;
      flush_i        = 1'b0;
      inst_addr_ok_i = 1'b0;
      inst_data_ok_i = 1'b0;
      inst_rdata_i   = 64'h0;
      resp_ready_i   = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc);
      fetch_valid_i  = 1'b1;
      fetch_pc_i     = pc;
      inst_addr_ok_i = 1'b1;
   endtask

   task automatic data(input logic [63:0] d);
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = d;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
      check_eq("rst_valid", {63'd0, resp_valid_o}, 64'd0);
      check_eq("rst_out",   {62'd0, outstanding_o}, 64'd0);
      check_eq("rst_disc",  {62'd0, discard_cnt_o}, 64'd0);
      check_eq("rst_pc",    {32'd0, resp_pc_o}, 64'd0);
      check_eq("rst_rdata", resp_rdata_o, 64'd0);

      // Basic fetch
      fetch(32'h1c00_0000);
      #1;
      check_eq("basic_req",   {63'd0, inst_req_o}, 64'd1);
      check_eq("basic_ready", {63'd0, fetch_ready_o}, 64'd1);
      check_eq("basic_addr",  {32'd0, inst_addr_o}, 64'h1c00_0000);
      cyc(); idle();
      check_eq("basic_out1", {62'd0, outstanding_o}, 64'd1);
      cyc();
      data(64'h0280_0400_0280_0800);
      #1;
      check_eq("basic_novalid", {63'd0, resp_valid_o}, 64'd0);
      cyc(); idle();
      check_eq("basic_out0",  {62'd0, outstanding_o}, 64'd0);
      check_eq("basic_valid", {63'd0, resp_valid_o}, 64'd1);
      check_eq("basic_pc",    {32'd0, resp_pc_o}, 64'h1c00_0000);
      check_eq("basic_rdata", resp_rdata_o, 64'h0280_0400_0280_0800);
      resp_ready_i = 1'b1;
      cyc(); idle();
      check_eq("basic_popped", {63'd0, resp_valid_o}, 64'd0);

      // Credit stall
      fetch(32'h1c00_0000); cyc();
      fetch(32'h1c00_0008); cyc();
      inst_addr_ok_i = 1'b0;
      fetch_valid_i  = 1'b1;
      #1;
      check_eq("credit_out2", {62'd0, outstanding_o}, 64'd2);
      check_eq("credit_req_a", {63'd0, inst_req_o}, 64'd0);
      data(64'h1111_1111_0000_0000); cyc();
      #1;
      check_eq("credit_req_b", {63'd0, inst_req_o}, 64'd0);
      data(64'h2222_2222_0000_0008); cyc();
      inst_data_ok_i = 1'b0;
      #1;
      check_eq("credit_req_c", {63'd0, inst_req_o}, 64'd0);
      check_eq("credit_pc_a",  {32'd0, resp_pc_o}, 64'h1c00_0000);
      check_eq("credit_rd_a",  resp_rdata_o, 64'h1111_1111_0000_0000);
      resp_ready_i = 1'b1;
      cyc();
      check_eq("credit_req_d", {63'd0, inst_req_o}, 64'd1);
      check_eq("credit_pc_b",  {32'd0, resp_pc_o}, 64'h1c00_0008);
      check_eq("credit_rd_b",  resp_rdata_o, 64'h2222_2222_0000_0008);
      cyc(); idle();
      check_eq("credit_empty", {63'd0, resp_valid_o}, 64'd0);

      // Flush with two in flight
      fetch(32'h1c00_0010); cyc();
      fetch(32'h1c00_0018); cyc();
      flush_i = 1'b1;
      #1;
      check_eq("flush_req", {63'd0, inst_req_o}, 64'd0);
      check_eq("flush_rdy", {63'd0, fetch_ready_o}, 64'd0);
      cyc(); idle();
      check_eq("flush_disc2", {62'd0, discard_cnt_o}, 64'd2);
      check_eq("flush_out2",  {62'd0, outstanding_o}, 64'd2);
      data(64'hdead_0000_0000_0010); cyc();
      check_eq("flush_nov1",  {63'd0, resp_valid_o}, 64'd0);
      check_eq("flush_disc1", {62'd0, discard_cnt_o}, 64'd1);
      data(64'hdead_0000_0000_0018); cyc(); idle();
      check_eq("flush_nov2",  {63'd0, resp_valid_o}, 64'd0);
      check_eq("flush_disc0", {62'd0, discard_cnt_o}, 64'd0);
      check_eq("flush_out0",  {62'd0, outstanding_o}, 64'd0);
      fetch(32'h1c00_0100); cyc(); idle();
      data(64'h0123_4567_89ab_cdef); cyc(); idle();
      check_eq("refetch_valid", {63'd0, resp_valid_o}, 64'd1);
      check_eq("refetch_pc",    {32'd0, resp_pc_o}, 64'h1c00_0100);
      check_eq("refetch_rdata", resp_rdata_o, 64'h0123_4567_89ab_cdef);
      resp_ready_i = 1'b1; cyc(); idle();

      // Flush coincident with data_ok
      fetch(32'h1c00_0200); cyc();
      fetch(32'h1c00_0208); cyc(); idle();
      flush_i = 1'b1;
      data(64'hbad0_0000_0000_0200); cyc(); idle();
      check_eq("fdat_disc1",  {62'd0, discard_cnt_o}, 64'd1);
      check_eq("fdat_out1",   {62'd0, outstanding_o}, 64'd1);
      check_eq("fdat_nov",    {63'd0, resp_valid_o}, 64'd0);
      data(64'hbad0_0000_0000_0208); cyc(); idle();
      check_eq("fdat_nov2",   {63'd0, resp_valid_o}, 64'd0);
      check_eq("fdat_out0",   {62'd0, outstanding_o}, 64'd0);

      // Simultaneous accept and return
      fetch(32'h1c00_0300); cyc(); idle();
      fetch(32'h1c00_0308);
      data(64'haaaa_0000_0000_0300); cyc(); idle();
      check_eq("sim_out1",  {62'd0, outstanding_o}, 64'd1);
      check_eq("sim_valid", {63'd0, resp_valid_o}, 64'd1);
      check_eq("sim_pc",    {32'd0, resp_pc_o}, 64'h1c00_0300);
      check_eq("sim_rdata", resp_rdata_o, 64'haaaa_0000_0000_0300);
      resp_ready_i = 1'b1;
      data(64'hbbbb_0000_0000_0308); cyc(); idle();
      check_eq("sim_out0",   {62'd0, outstanding_o}, 64'd0);
      check_eq("sim_valid2", {63'd0, resp_valid_o}, 64'd1);
      check_eq("sim_pc2",    {32'd0, resp_pc_o}, 64'h1c00_0308);
      check_eq("sim_rdata2", resp_rdata_o, 64'hbbbb_0000_0000_0308);
      resp_ready_i = 1'b1; cyc(); idle();
      check_eq("sim_empty", {63'd0, resp_valid_o}, 64'd0);

      // Reset mid-operation: one buffered response and one in flight
      fetch(32'h1c00_0400); cyc(); idle();
      data(64'hcccc_0000_0000_0400); cyc(); idle();
      fetch(32'h1c00_0408); cyc(); idle();
      check_eq("prerst_out",   {62'd0, outstanding_o}, 64'd1);
      check_eq("prerst_valid", {63'd0, resp_valid_o}, 64'd1);
      rst_n = 1'b0; cyc();
      rst_n = 1'b1;
      check_eq("mrst_valid", {63'd0, resp_valid_o}, 64'd0);
      check_eq("mrst_out",   {62'd0, outstanding_o}, 64'd0);
      check_eq("mrst_disc",  {62'd0, discard_cnt_o}, 64'd0);
      check_eq("mrst_pc",    {32'd0, resp_pc_o}, 64'd0);
      check_eq("mrst_rdata", resp_rdata_o, 64'd0);
      data(64'heeee_0000_0000_0408); cyc(); idle();
      check_eq("stray_valid", {63'd0, resp_valid_o}, 64'd0);
      check_eq("stray_out",   {62'd0, outstanding_o}, 64'd0);
      check_eq("stray_disc",  {62'd0, discard_cnt_o}, 64'd0);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
